// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, request format and FSM state type for the
// pixel writer and the display-side read path.
package fb_pkg;

    localparam int FB_COLS     = 80;
    localparam int FB_ROWS     = 60;
    localparam int FB_WORDS    = FB_COLS * FB_ROWS;
    localparam int FB_AW       = 13;
    localparam int PIX_W       = 12;
    localparam int COORD_W     = 10;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int BLOCK_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_state_e;

    // One queued write: block address plus colour.
    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [PIX_W-1:0] color;
    } fb_req_t;

    localparam int FB_REQ_W = FB_AW + PIX_W;

    // Screen pixel coordinate to block address: (y>>3)*cols + (x>>3).
    function automatic logic [FB_AW-1:0] fb_block_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [FB_AW-1:0]   cols
    );
        logic [FB_AW-1:0] row;
        logic [FB_AW-1:0] col;
        row = FB_AW'(y >> BLOCK_SHIFT);
        col = FB_AW'(x >> BLOCK_SHIFT);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/fb_req_fifo.sv
// Synchronous request FIFO with full/empty flags and an occupancy count.
// Push while full is only honoured together with a pop; pop while empty is ignored.
module fb_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values from the guarded push/pop.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the count gates them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel-write front end for the block framebuffer: range-checks and maps
// screen coordinates to block addresses, queues them, and drives BRAM port B
// either from the queue or from the clear-screen sweep.
module fb_pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter bit BLANK_ONLY = 1'b0,
    parameter int FB_COLS    = fb_pkg::FB_COLS,
    parameter int FB_ROWS    = fb_pkg::FB_ROWS
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [fb_pkg::COORD_W-1:0] wr_x,
    input  logic [fb_pkg::COORD_W-1:0] wr_y,
    input  logic [fb_pkg::PIX_W-1:0]  wr_color,
    input  logic                      clear_req,
    input  logic [fb_pkg::PIX_W-1:0]  clear_color,
    input  logic                      frame_blank,
    output logic                      fb_we,
    output logic [fb_pkg::FB_AW-1:0]  fb_addr,
    output logic [fb_pkg::PIX_W-1:0]  fb_din,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);

    import fb_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COORD_W-1:0] X_LIMIT   = COORD_W'(FB_COLS << BLOCK_SHIFT);
    localparam logic [COORD_W-1:0] Y_LIMIT   = COORD_W'(FB_ROWS << BLOCK_SHIFT);
    localparam logic [FB_AW-1:0]   COLS_W    = FB_AW'(FB_COLS);
    localparam logic [FB_AW-1:0]   LAST_ADDR = FB_AW'(FB_COLS * FB_ROWS - 1);
    localparam logic [7:0]         DROP_MAX  = 8'hFF;

    logic                enable;
    logic                accept;
    logic                in_range;
    logic                push;
    logic                pop;
    logic                start_clear;
    fb_req_t             req_in;
    fb_req_t             req_out;
    logic [FB_REQ_W-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    count_next;

    fb_state_e           state_q, state_d;
    logic                fb_we_q, fb_we_d;
    logic [FB_AW-1:0]    fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]    fb_din_q, fb_din_d;
    logic                busy_q, busy_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [FB_AW-1:0]    clr_addr_q, clr_addr_d;
    logic [PIX_W-1:0]    clr_color_q, clr_color_d;

    // Out-of-range requests are still handshaked, just never queued.
    assign enable      = frame_blank | ~BLANK_ONLY;
    assign wr_ready    = !reset && !fifo_full;
    assign accept      = wr_valid && wr_ready;
    assign in_range    = (wr_x < X_LIMIT) && (wr_y < Y_LIMIT);
    assign push        = accept && in_range;
    assign start_clear = clear_req && (state_q != CLEAR);

    assign req_in.addr  = fb_block_addr(wr_x, wr_y, COLS_W);
    assign req_in.color = wr_color;
    assign req_out      = fifo_dout;

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_din   = fb_din_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_cnt_q;

    fb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FB_REQ_W)
    ) u_fifo (
        .clk   (pclk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (req_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state and write-port logic for the IDLE/DRAIN/CLEAR sequencer.
    always_comb begin
        state_d     = state_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_din_d    = fb_din_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        pop         = 1'b0;

        if (start_clear) begin
            // The clear pulse is captured even outside blanking so it is
            // never lost; the sweep itself only advances on enabled cycles.
            state_d     = CLEAR;
            clr_color_d = clear_color;
            if (enable) begin
                fb_we_d    = 1'b1;
                fb_addr_d  = '0;
                fb_din_d   = clear_color;
                clr_addr_d = FB_AW'(1);
            end else begin
                clr_addr_d = '0;
            end
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    // Looking at the incoming push lets a fresh request
                    // reach the BRAM two cycles after acceptance.
                    if (!fifo_empty || push) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        fb_we_d   = 1'b1;
                        fb_addr_d = req_out.addr;
                        fb_din_d  = req_out.color;
                    end else if (!push) begin
                        state_d = IDLE;
                    end
                end
                CLEAR: begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = clr_addr_q;
                    fb_din_d  = clr_color_q;
                    if (clr_addr_q == LAST_ADDR) begin
                        clr_addr_d = '0;
                        state_d    = (!fifo_empty || push) ? DRAIN : IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Busy looks ahead at the FIFO occupancy so it is registered with the FSM.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
        busy_d = (state_d != IDLE) || (count_next != '0);

        drop_cnt_d = drop_cnt_q;
        if (accept && !in_range && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Sequencer state and registered write-port outputs; reset aborts any sweep.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_din_q    <= '0;
            busy_q      <= 1'b0;
            drop_cnt_q  <= '0;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_din_q    <= fb_din_d;
            busy_q      <= busy_d;
            drop_cnt_q  <= drop_cnt_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: stimulus queues expected BRAM writes,
// a negedge monitor pops and compares every fb_we it sees.
module tb_fb_pixel_writer;

    logic        pclk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic [11:0] wr_color;
    logic        clear_req;
    logic [11:0] clear_color;
    logic        frame_blank;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [11:0] fb_din;
    logic        busy;
    logic [7:0]  drop_cnt;

    typedef struct packed {
        logic [12:0] a;
        logic [11:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   wr_count = 0;

    always #5 pclk = ~pclk;

    fb_pixel_writer #(
        .FIFO_DEPTH (4),
        .BLANK_ONLY (1'b1),
        .FB_COLS    (80),
        .FB_ROWS    (60)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .frame_blank (frame_blank),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_din      (fb_din),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic expect_wr(input logic [12:0] a, input logic [11:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [11:0] c);
        wr_valid = 1'b1;
        wr_x     = x;
        wr_y     = y;
        wr_color = c;
        check("send_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {31'd0, (busy === 1'b0 && exp_q.size() == 0)}, 1);
    endtask

    // Monitor: every BRAM write must match the head of the expected queue.
    always @(negedge pclk) begin
        if (fb_we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0d din=0x%0h, nothing expected", fb_addr, fb_din);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", fb_addr, mon_e.a);
                check("write_din", fb_din, mon_e.d);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        int n;
        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_x        = '0;
        wr_y        = '0;
        wr_color    = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        frame_blank = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_din", fb_din, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ready", wr_ready, 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", wr_ready, 1);

        // Single write: (17,9) -> block (2,1) -> 1*80+2 = 82
        expect_wr(13'd82, 12'hF00);
        send(10'd17, 10'd9, 12'hF00);
        check("single_n1_busy", busy, 1);
        check("single_n1_we", fb_we, 0);
        tick();
        check("single_n2_we", fb_we, 1);
        check("single_n2_addr", fb_addr, 82);
        check("single_n2_din", fb_din, 12'hF00);
        check("single_n2_busy", busy, 1);
        tick();
        check("single_n3_we", fb_we, 0);
        check("single_n3_busy", busy, 0);

        // Burst of six back-to-back requests
        begin
            logic [9:0]  bx [6];
            logic [9:0]  by [6];
            logic [12:0] ba [6];
            bx = '{10'd0, 10'd639, 10'd0,   10'd639, 10'd320, 10'd7};
            by = '{10'd0, 10'd0,   10'd479, 10'd479, 10'd240, 10'd15};
            ba = '{13'd0, 13'd79,  13'd4720, 13'd4799, 13'd2440, 13'd80};
            for (int i = 0; i < 6; i++) begin
                wr_valid = 1'b1;
                wr_x     = bx[i];
                wr_y     = by[i];
                wr_color = 12'(i + 1);
                check("burst_ready", wr_ready, 1);
                expect_wr(ba[i], 12'(i + 1));
                tick();
            end
            wr_valid = 1'b0;
        end
        wait_idle(50, "burst");

        // Out-of-range requests: handshaked, counted, never written
        send(10'd640, 10'd0, 12'h111);
        send(10'd0, 10'd480, 12'h222);
        repeat (3) tick();
        check("drop_two", drop_cnt, 2);
        check("drop_busy", busy, 0);
        wr_valid = 1'b1;
        wr_x     = 10'd1023;
        wr_y     = 10'd1023;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 251) check("drop_254", drop_cnt, 254);
        end
        wr_valid = 1'b0;
        tick();
        check("drop_sat", drop_cnt, 255);

        // Blank gating: write held until frame_blank rises
        frame_blank = 1'b0;
        expect_wr(13'd0, 12'hABC);
        send(10'd0, 10'd0, 12'hABC);
        for (int i = 0; i < 6; i++) begin
            check("gated_no_we", fb_we, 0);
            tick();
        end
        check("gated_busy", busy, 1);
        frame_blank = 1'b1;
        tick();
        check("ungate_n1_we", fb_we, 0);
        tick();
        check("ungate_n2_we", fb_we, 1);
        check("ungate_n2_addr", fb_addr, 0);
        wait_idle(20, "ungate");

        // Clear with queued entries plus one accepted alongside clear_req
        frame_blank = 1'b0;
        send(10'd8, 10'd8, 12'h111);
        send(10'd639, 10'd479, 12'h123);
        check("preclear_busy", busy, 1);
        for (int a = 0; a < 4800; a++) expect_wr(13'(a), 12'h0A5);
        expect_wr(13'd81, 12'h111);
        expect_wr(13'd4799, 12'h123);
        expect_wr(13'd2012, 12'h5A5);
        wc0         = wr_count;
        frame_blank = 1'b1;
        clear_req   = 1'b1;
        clear_color = 12'h0A5;
        wr_valid    = 1'b1;
        wr_x        = 10'd100;
        wr_y        = 10'd200;
        wr_color    = 12'h5A5;
        tick();
        clear_req   = 1'b0;
        wr_valid    = 1'b0;
        clear_color = 12'hFFF;
        check("clear_first_we", fb_we, 1);
        check("clear_first_addr", fb_addr, 0);
        check("clear_first_din", fb_din, 12'h0A5);
        n = 0;
        while (fb_addr !== 13'd2000 && n < 5000) begin
            tick();
            n++;
        end
        check("clear_reach_2000", fb_addr, 2000);
        frame_blank = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("clear_paused_we", fb_we, 0);
        end
        check("clear_paused_busy", busy, 1);
        frame_blank = 1'b1;
        clear_req   = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clear_resume_we", fb_we, 1);
        check("clear_resume_addr", fb_addr, 2001);
        wait_idle(6000, "clear");
        check("clear_total_writes", wr_count - wc0, 4803);

        // Reset in the middle of a clear aborts everything
        for (int a = 0; a < 4800; a++) expect_wr(13'(a), 12'h777);
        clear_req   = 1'b1;
        clear_color = 12'h777;
        tick();
        clear_req = 1'b0;
        send(10'd16, 10'd16, 12'h222);
        send(10'd24, 10'd24, 12'h333);
        n = 0;
        while (fb_addr !== 13'd1000 && n < 2000) begin
            tick();
            n++;
        end
        check("rst_reach_1000", fb_addr, 1000);
        reset = 1'b1;
        tick();
        check("midrst_fb_we", fb_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop_cnt, 0);
        check("midrst_ready", wr_ready, 0);
        exp_q.delete();
        wc0   = wr_count;
        reset = 1'b0;
        tick();
        check("midrst_ready_after", wr_ready, 1);
        repeat (20) tick();
        check("midrst_no_writes", wr_count - wc0, 0);
        check("midrst_idle_busy", busy, 0);

        // Fresh write after reset: (40,32) -> 4*80+5 = 325
        expect_wr(13'd325, 12'h0F0);
        send(10'd40, 10'd32, 12'h0F0);
        wait_idle(20, "post_rst");
        check("post_rst_writes", wr_count - wc0, 1);

        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
